// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI slave register bank with RW_REG_COUNT read-write bytes at the
// low addresses and RO_REG_COUNT read-only bytes above them. Multi-byte transfers
// auto-increment the address. All SPI pins are oversampled in the clk domain.
// Optional build macro SPI_REG_WR_STROBE_EN adds the wr_strobe output (one-clk
// pulse per RW byte, aligned with that byte's update).
module spi_reg_bank #(
   parameter int                          RW_REG_COUNT = 8,
   parameter int                          RO_REG_COUNT = 4,
   parameter bit                          CPOL         = 1'b0,
   parameter bit                          CPHA         = 1'b0,
   parameter logic [RW_REG_COUNT*8-1:0]   RW_RESET     = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           spi_clk,
   input  logic                           spi_mosi,
   input  logic                           spi_cs,
   output logic                           spi_miso,
   output logic [RW_REG_COUNT*8-1:0]      rw_data,
   input  logic [RO_REG_COUNT*8-1:0]      ro_data
`ifdef SPI_REG_WR_STROBE_EN
   ,
   output logic [RW_REG_COUNT-1:0]        wr_strobe
`endif
);

   localparam int TOTAL = RW_REG_COUNT + RO_REG_COUNT;

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

   // synchroniser stages: _p0/_p1 form the 2-FF synchroniser, _p2 is edge history
   logic          sclk_p0, sclk_p1, sclk_p2;
   logic          cs_p0, cs_p1, cs_p2;
   logic          mosi_p0, mosi_p1;

   logic          sclk_rise, sclk_fall;
   logic          sample_edge, shift_edge;
   logic          cs_fall, cs_rise;

   state_t        state;
   logic [2:0]    bit_cnt;
   logic [6:0]    rx_sr;
   logic [7:0]    rx_byte;
   logic [7:0]    tx_sr;
   logic [6:0]    addr;
   logic          rnw;

   // write commit stage, one clk behind the completing sample edge
   logic          wr_vld_p0;
   logic [6:0]    wr_addr_p0;
   logic [7:0]    wr_byte_p0;

   // Next address: wraps from the last implemented byte back to 0; beyond the
   // implemented range the 7-bit address simply rolls over.
   function automatic logic [6:0] addr_inc(input logic [6:0] a);
      return (int'(a) == TOTAL - 1) ? 7'd0 : a + 7'd1;
   endfunction

   // Byte visible to a read at address a; unimplemented addresses read as zero.
   function automatic logic [7:0] byte_at(input logic [6:0] a);
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < RW_REG_COUNT; i++)
         if (a == 7'(i)) b = rw_data[8*i +: 8];
      for (int i = 0; i < RO_REG_COUNT; i++)
         if (a == 7'(RW_REG_COUNT + i)) b = ro_data[8*i +: 8];
      return b;
   endfunction

   // Bring the asynchronous SPI pins into the clk domain. The cs chain resets
   // to "selected" so a cs held low through reset does not look like a new fall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_p0 <= CPOL;
         sclk_p1 <= CPOL;
         sclk_p2 <= CPOL;
         cs_p0   <= 1'b0;
         cs_p1   <= 1'b0;
         cs_p2   <= 1'b0;
         mosi_p0 <= 1'b0;
         mosi_p1 <= 1'b0;
      end else begin
         sclk_p0 <= spi_clk;
         sclk_p1 <= sclk_p0;
         sclk_p2 <= sclk_p1;
         cs_p0   <= spi_cs;
         cs_p1   <= cs_p0;
         cs_p2   <= cs_p1;
         mosi_p0 <= spi_mosi;
         mosi_p1 <= mosi_p0;
      end
   end

   // Decode synchronised edges into sample/shift events for the selected SPI mode.
   always_comb begin
      sclk_rise   = sclk_p1 & ~sclk_p2;
      sclk_fall   = ~sclk_p1 & sclk_p2;
      cs_fall     = cs_p2 & ~cs_p1;
      cs_rise     = ~cs_p2 & cs_p1;
      sample_edge = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;
      shift_edge  = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;
      rx_byte     = {rx_sr, mosi_p1};
   end

   // Transaction FSM: command decode, byte assembly, read loading and MISO shifting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         rx_sr      <= 7'd0;
         tx_sr      <= 8'd0;
         addr       <= 7'd0;
         rnw        <= 1'b0;
         spi_miso   <= 1'b0;
         wr_vld_p0  <= 1'b0;
         wr_addr_p0 <= 7'd0;
         wr_byte_p0 <= 8'd0;
      end else begin
         wr_vld_p0 <= 1'b0;
         if (cs_rise) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            rx_sr    <= 7'd0;
            tx_sr    <= 8'd0;
            spi_miso <= 1'b0;
         end else if (cs_fall) begin
            state    <= CMD;
            bit_cnt  <= 3'd0;
            rx_sr    <= 7'd0;
            tx_sr    <= 8'd0;
            spi_miso <= 1'b0;
         end else if (state != IDLE) begin
            if (sample_edge) begin
               rx_sr   <= rx_byte[6:0];
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (state == CMD) begin
                     state <= DATA;
                     rnw   <= rx_byte[7];
                     addr  <= rx_byte[6:0];
                     if (rx_byte[7]) tx_sr <= byte_at(rx_byte[6:0]);
                  end else begin
                     addr <= addr_inc(addr);
                     if (rnw) begin
                        tx_sr <= byte_at(addr_inc(addr));
                     end else if (int'(addr) < RW_REG_COUNT) begin
                        wr_vld_p0  <= 1'b1;
                        wr_addr_p0 <= addr;
                        wr_byte_p0 <= rx_byte;
                     end
                  end
               end
            end
            if (shift_edge) begin
               if (state == DATA) begin
                  spi_miso <= tx_sr[7];
                  tx_sr    <= {tx_sr[6:0], 1'b0};
               end else begin
                  spi_miso <= 1'b0;
               end
            end
         end
      end
   end

   // Commit a completed write byte into the RW register image; reset has priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rw_data <= RW_RESET;
      end else if (wr_vld_p0) begin
         for (int i = 0; i < RW_REG_COUNT; i++)
            if (wr_addr_p0 == 7'(i)) rw_data[8*i +: 8] <= wr_byte_p0;
      end
   end

`ifdef SPI_REG_WR_STROBE_EN
   // Per-byte write pulse, registered on the same edge that updates rw_data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_strobe <= '0;
      end else begin
         for (int i = 0; i < RW_REG_COUNT; i++)
            wr_strobe[i] <= wr_vld_p0 && (wr_addr_p0 == 7'(i));
      end
   end
`else
   // Without the strobe option the commit stage drives rw_data only.
`endif

endmodule
